jt12_timer_regs: RTL and testbench

- Host-side register writer and status reader for the JT12 timer pair.
- Decodes CPU address/data writes to registers 0x24–0x27 (part I) into timer A/B values, run (load), flag-clear and IRQ-enable controls.
- Reads back the busy and timer flags as the status byte.
- Sits between the 68k/Z80 bus glue and jt12_timers; generates a busy window after each data write.

---
 rtl/jt12_timer_regs.sv | 119 +++++++++++
 tb/tb_jt12_timer_regs.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_timer_regs.sv
// Host-side register writer / status reader for the JT12 timer pair (part I, regs 0x24-0x27).
// Optional CSM key-on pulse generation is enabled by defining JT12_CSM_EN.
module jt12_timer_regs #(
  parameter int BUSY_CYCLES = 32,
  parameter int BUSY_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic [1:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        busy,
  output logic [9:0]  value_A,
  output logic [7:0]  value_B,
  output logic        load_A,
  output logic        load_B,
  output logic        clr_flag_A,
  output logic        clr_flag_B,
  output logic        enable_irq_A,
  output logic        enable_irq_B,
  input  logic        flag_A,
  input  logic        flag_B,
  input  logic        overflow_A,
  output logic        csm_keyon
);

  localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(BUSY_CYCLES);

  logic              we, we_q, write_edge;
  logic              addr_wr, data_wr, timer_wr;
  logic [7:0]        sel_addr;
  logic              sel_part;
  logic [1:0]        mode;
  logic              run_A, run_B;
  logic [BUSY_W-1:0] busy_cnt;

  // A held strobe acts once: only the low-to-high transition of we fires.
  assign we         = ~cs_n & ~wr_n;
  assign write_edge = we & ~we_q;
  assign addr_wr    = write_edge & ~addr[0];
  assign data_wr    = write_edge &  addr[0];
  assign timer_wr   = data_wr & ~sel_part;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      sel_addr     <= 8'h00;
      sel_part     <= 1'b0;
      value_A      <= 10'd0;
      value_B      <= 8'd0;
      mode         <= 2'b00;
      run_A        <= 1'b0;
      run_B        <= 1'b0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
    end else begin
      we_q       <= we;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      if (addr_wr) begin
        sel_addr <= din;
        sel_part <= addr[1];
      end
      if (timer_wr) begin
        case (sel_addr)
          8'h24: value_A[9:2] <= din;
          8'h25: value_A[1:0] <= din[1:0];
          8'h26: value_B      <= din;
          8'h27: begin
            mode         <= din[7:6];
            clr_flag_B   <= din[5];
            clr_flag_A   <= din[4];
            enable_irq_B <= din[3];
            enable_irq_A <= din[2];
            run_B        <= din[1];
            run_A        <= din[0];
          end
          default: ;
        endcase
      end
    end
  end

  // Any data write (either part, any register) restarts the busy window.
  always_ff @(posedge clk) begin
    if (rst)
      busy_cnt <= '0;
    else if (data_wr)
      busy_cnt <= BUSY_LOAD;
    else if (clk_en && busy_cnt != '0)
      busy_cnt <= busy_cnt - 1'b1;
  end

  assign busy   = (busy_cnt != '0);
  assign load_A = ~run_A;
  assign load_B = ~run_B;
  assign dout   = {busy, 5'b0_0000, flag_B, flag_A};

`ifdef JT12_CSM_EN
  always_ff @(posedge clk) begin
    if (rst)
      csm_keyon <= 1'b0;
    else
      csm_keyon <= overflow_A && (mode == 2'b10);
  end
`else
  logic unused_csm;
  assign unused_csm = ^{mode, overflow_A};
  assign csm_keyon  = 1'b0;
`endif

endmodule

// File: tb/tb_jt12_timer_regs.sv
// Randomized self-checking bench for jt12_timer_regs against a register-map model.
// Honors JT12_CSM_EN the same way as the design.
module tb_jt12_timer_regs;

  localparam int BUSY = 32;

  logic       clk = 1'b0;
  logic       rst, clk_en, cs_n, wr_n;
  logic [1:0] addr;
  logic [7:0] din, dout;
  logic       busy, load_A, load_B, clr_flag_A, clr_flag_B;
  logic       enable_irq_A, enable_irq_B, flag_A, flag_B, overflow_A, csm_keyon;
  logic [9:0] value_A;
  logic [7:0] value_B;

  jt12_timer_regs #(.BUSY_CYCLES(BUSY), .BUSY_W(6)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .cs_n(cs_n), .wr_n(wr_n),
    .addr(addr), .din(din), .dout(dout), .busy(busy),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
    .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
    .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A), .csm_keyon(csm_keyon)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int en_ticks = 0, clr_a_seen = 0, clr_b_seen = 0, csm_seen = 0;
  int last_wr_ticks = 0;

  // Observers of pulse outputs and clk_en ticks, sampled at the rising edge.
  always @(posedge clk) begin
    en_ticks   <= en_ticks + int'(clk_en);
    clr_a_seen <= clr_a_seen + int'(clr_flag_A);
    clr_b_seen <= clr_b_seen + int'(clr_flag_B);
    csm_seen   <= csm_seen + int'(csm_keyon);
  end

  initial begin
    clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1 clk_en = 1'($urandom_range(0, 1));
    end
  end

  // Reference model: the register map as the host sees it.
  logic [7:0] m_sel = 8'h00;
  logic       m_part = 1'b0;
  logic [9:0] m_va = '0;
  logic [7:0] m_vb = '0;
  logic [1:0] m_mode = '0;
  logic       m_run_a = 0, m_run_b = 0, m_ien_a = 0, m_ien_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sel = 8'h00; m_part = 1'b0; m_va = '0; m_vb = '0; m_mode = '0;
    m_run_a = 0; m_run_b = 0; m_ien_a = 0; m_ien_b = 0;
  endtask

  // One bus cycle; strobe held for 'hold' clocks. Checks clear pulses and busy start.
  task automatic bus_write(input bit a0, input bit part, input logic [7:0] data, input int hold);
    int ca0, cb0;
    bit hit27;
    ca0 = clr_a_seen; cb0 = clr_b_seen;
    hit27 = a0 && !m_part && m_sel == 8'h27;
    cs_n = 0; wr_n = 0; addr = {part, a0}; din = data;
    cyc(1);
    if (a0) last_wr_ticks = en_ticks;
    if (hold > 1) cyc(hold - 1);
    cs_n = 1; wr_n = 1;
    cyc(2);
    if (!a0) begin
      m_sel = data; m_part = part;
    end else begin
      if (!m_part) begin
        case (m_sel)
          8'h24: m_va = {data, m_va[1:0]};
          8'h25: m_va = {m_va[9:2], data[1:0]};
          8'h26: m_vb = data;
          8'h27: begin
            m_mode = data[7:6]; m_ien_b = data[3]; m_ien_a = data[2];
            m_run_b = data[1]; m_run_a = data[0];
          end
          default: ;
        endcase
      end
      check("clr_a_count", clr_a_seen - ca0, (hit27 && data[4]) ? 1 : 0);
      check("clr_b_count", clr_b_seen - cb0, (hit27 && data[5]) ? 1 : 0);
      check("busy_after_wr", busy, 1);
      check("dout_busy", dout, {1'b1, 5'b0, flag_B, flag_A});
    end
  endtask

  task automatic reg_write(input logic [7:0] r, input logic [7:0] data);
    bus_write(0, 0, r, 1);
    bus_write(1, 0, data, 1);
  endtask

  task automatic wait_idle(input bit check_ticks);
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin done = 1; break; end
      cyc(1);
    end
    if (!done) check("busy_timeout", 1, 0);
    else if (check_ticks) check("busy_ticks", en_ticks - last_wr_ticks, BUSY);
  endtask

  task automatic check_regs();
    check("value_A", value_A, m_va);
    check("value_B", value_B, m_vb);
    check("load_A", load_A, !m_run_a);
    check("load_B", load_B, !m_run_b);
    check("irq_en_A", enable_irq_A, m_ien_a);
    check("irq_en_B", enable_irq_B, m_ien_b);
  endtask

  task automatic csm_probe(input string tag);
    int c0;
    bit exp;
    c0 = csm_seen;
`ifdef JT12_CSM_EN
    exp = (m_mode == 2'b10);
`else
    exp = 0;
`endif
    overflow_A = 1; cyc(1);
    overflow_A = 0; cyc(3);
    check(tag, csm_seen - c0, exp ? 1 : 0);
  endtask

  initial begin
    rst = 1; cs_n = 1; wr_n = 1; addr = 0; din = 0;
    flag_A = 0; flag_B = 0; overflow_A = 0;
    cyc(3);
    rst = 0;
    cyc(2);

    check("rst_dout", dout, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_csm", csm_keyon, 0);
    check_regs();

    reg_write(8'h24, 8'hAB);
    wait_idle(1);
    reg_write(8'h25, 8'h03);
    wait_idle(1);
    reg_write(8'h26, 8'h5C);
    wait_idle(1);
    check("value_A_2AF", value_A, 10'h2AF);
    check("value_B_5C", value_B, 8'h5C);

    reg_write(8'h27, 8'h0F);
    check_regs();
    flag_A = 1; flag_B = 0;
    cyc(1);
    check("dout_81", dout, 8'h81);
    wait_idle(1);
    check("dout_01", dout, 8'h01);
    reg_write(8'h27, 8'h3F);
    check_regs();

    // Part II access must not touch timer registers yet still start busy.
    wait_idle(0);
    bus_write(0, 1, 8'h24, 1);
    bus_write(1, 1, 8'hFF, 1);
    check_regs();
    wait_idle(1);

    // Long strobe: a single action.
    bus_write(0, 0, 8'h27, 1);
    bus_write(1, 0, 8'h10, 10);
    check_regs();

    // CSM key-on.
    reg_write(8'h27, 8'h81);
    csm_probe("csm_mode10");
    reg_write(8'h27, 8'h41);
    csm_probe("csm_mode01");

    // Random register traffic.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] r, d;
      int pick;
      pick = $urandom_range(0, 9);
      r = (pick < 8) ? 8'(8'h24 + pick % 4) : 8'($urandom);
      d = 8'($urandom);
      flag_A = 1'($urandom); flag_B = 1'($urandom);
      bus_write(0, ($urandom_range(0, 5) == 0), r, $urandom_range(1, 3));
      bus_write(1, 1'($urandom), d, $urandom_range(1, 4));
      check_regs();
      if (i % 15 == 7) csm_probe("csm_rand");
    end
    wait_idle(1);
    check("dout_idle", dout, {1'b0, 5'b0, flag_B, flag_A});

    // Reset while a data strobe is held: the held strobe counts as a new edge.
    bus_write(0, 0, 8'h26, 1);
    cs_n = 0; wr_n = 0; addr = 2'b01; din = 8'h77;
    cyc(1);
    rst = 1;
    cyc(2);
    model_reset();
    check("rst_mid_busy", busy, 0);
    rst = 0;
    cyc(2);
    check("post_rst_edge_busy", busy, 1);
    cs_n = 1; wr_n = 1;
    cyc(2);
    check_regs();
    wait_idle(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
